// File: rtl/usb_report_pkg.sv
// Shared definitions for the status-report IN endpoint: FSM states,
// packet header byte and the two possible packet lengths.
package usb_report_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_PUT      = 3'd2,
    ST_DONE     = 3'd3,
    ST_WAIT_ACK = 3'd4
  } state_e;

  localparam logic [7:0] PKT_HDR       = 8'hA2;
  localparam int         PKT_LEN_PLAIN = 3;  // header, seq, status
  localparam int         PKT_LEN_CKSUM = 4;  // ... plus XOR checksum

endpackage

// File: rtl/usb_report_in_ep.sv
// Status-report IN endpoint: sends a short packet {A2, seq, status[, xor]}
// to a shared USB IN buffer whenever triggered or the status byte changes.
// Optional checksum byte enabled by defining USB_REPORT_CKSUM_EN.
module usb_report_in_ep
  import usb_report_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic       in_ep_req,
  input  logic       in_ep_grant,
  input  logic       in_ep_data_free,
  output logic       in_ep_data_put,
  output logic [7:0] in_ep_data,
  output logic       in_ep_data_done,
  output logic       in_ep_stall,
  input  logic       in_ep_acked,
  input  logic [7:0] status,
  input  logic       report_trig,
  output logic       busy
);

`ifdef USB_REPORT_CKSUM_EN
  localparam int PKT_LEN = PKT_LEN_CKSUM;
`else
  localparam int PKT_LEN = PKT_LEN_PLAIN;
`endif
  localparam logic [1:0] LAST_IDX = 2'(PKT_LEN - 1);

  state_e     state_q;
  logic [1:0] idx_q;
  logic [7:0] seq_q;
  logic [7:0] snap_q;
  logic [7:0] last_q;
  logic       pending_q;
  logic       done_q;

  logic       go;
  logic       pend_set;
  logic [7:0] byte_d;

  // While idle a report is owed if status moved away from what the host
  // last acknowledged; while busy, compare against the byte in flight so
  // the current packet does not re-trigger itself.
  assign pend_set = report_trig ||
                    ((state_q == ST_IDLE) ? (status != last_q) : (status != snap_q));
  assign go       = (state_q == ST_IDLE) && pending_q;

  assign in_ep_req       = (state_q == ST_REQ) || (state_q == ST_PUT) || (state_q == ST_DONE);
  assign in_ep_data_put  = (state_q == ST_PUT) && in_ep_grant && in_ep_data_free;
  assign in_ep_data      = byte_d;
  assign in_ep_data_done = done_q;
  assign in_ep_stall     = 1'b0;
  assign busy            = (state_q != ST_IDLE);

  // Byte mux for the current packet index; zero outside PUT.
  always_comb begin
    byte_d = 8'h00;
    if (state_q == ST_PUT) begin
      case (idx_q)
        2'd0:    byte_d = PKT_HDR;
        2'd1:    byte_d = seq_q;
        2'd2:    byte_d = snap_q;
`ifdef USB_REPORT_CKSUM_EN
        2'd3:    byte_d = PKT_HDR ^ seq_q ^ snap_q;
`endif
        default: byte_d = 8'h00;
      endcase
    end
  end

  // Pending flag: the transition into REQ consumes it, otherwise any new
  // trigger/change latches it (at most one outstanding report).
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         pending_q <= 1'b0;
    else if (go)       pending_q <= 1'b0;
    else if (pend_set) pending_q <= 1'b1;
  end

  // Packet FSM with index, sequence, snapshot and last-sent bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      seq_q   <= 8'h00;
      snap_q  <= 8'h00;
      last_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pending_q) begin
            snap_q  <= status;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          idx_q <= 2'd0;
          if (in_ep_grant) state_q <= ST_PUT;
        end
        ST_PUT: begin
          if (in_ep_data_put) begin
            if (idx_q == LAST_IDX) begin
              idx_q   <= 2'd0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        ST_DONE: state_q <= ST_WAIT_ACK;
        ST_WAIT_ACK: begin
          if (in_ep_acked) begin
            seq_q   <= seq_q + 8'd1;
            last_q  <= snap_q;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_report_in_ep.sv
// Self-checking bench for usb_report_in_ep. Packets are collected from the
// buffer interface under random grant/free/ack noise and compared with the
// packet the reference model says should go out next.
module tb_usb_report_in_ep;

`ifdef USB_REPORT_CKSUM_EN
  localparam int PLEN = 4;
`else
  localparam int PLEN = 3;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       in_ep_req, in_ep_grant, in_ep_data_free, in_ep_data_put;
  logic [7:0] in_ep_data;
  logic       in_ep_data_done, in_ep_stall, in_ep_acked;
  logic [7:0] status;
  logic       report_trig, busy;

  int total = 0;
  int bad   = 0;
  logic [7:0] m_seq;  // model: sequence number of the next packet

  always #5 clk = ~clk;

  usb_report_in_ep dut (
    .clk             (clk),
    .reset           (reset),
    .in_ep_req       (in_ep_req),
    .in_ep_grant     (in_ep_grant),
    .in_ep_data_free (in_ep_data_free),
    .in_ep_data_put  (in_ep_data_put),
    .in_ep_data      (in_ep_data),
    .in_ep_data_done (in_ep_data_done),
    .in_ep_stall     (in_ep_stall),
    .in_ep_acked     (in_ep_acked),
    .status          (status),
    .report_trig     (report_trig),
    .busy            (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All outputs must be zero (reset, idle).
  task automatic chk_outs_zero(input string tag);
    chk(tag, {20'h0, in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, busy, in_ep_stall}, 32'h0);
  endtask

  // n cycles with no request, put or busy.
  task automatic idle_chk(input int n, input string tag);
    int hits = 0;
    repeat (n) begin
      @(negedge clk); #1;
      if (in_ep_req || in_ep_data_put || busy) hits++;
    end
    chk(tag, 32'(hits), 32'h0);
  endtask

  // Collect one packet, check it against the model, acknowledge it.
  task automatic run_pkt(input bit rnd, input bit do_trig, input bit trig_wait,
                         input logic [7:0] exp_snap, input string tag);
    logic [7:0]  got[$];
    logic [7:0]  e[4];
    logic [31:0] g;
    int cyc = 0;
    int zbad = 0;
    bit seen = 0;
    e[0] = 8'hA2; e[1] = m_seq; e[2] = exp_snap; e[3] = e[0] ^ e[1] ^ e[2];
    while (!seen && cyc < 300) begin
      @(negedge clk); cyc++;
      report_trig     = do_trig && (cyc == 1);
      in_ep_grant     = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_ep_data_free = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_ep_acked     = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (in_ep_data_put) got.push_back(in_ep_data);
      if (!in_ep_req && in_ep_data !== 8'h00) zbad++;
      if (in_ep_data_done) begin
        seen = 1;
        chk({tag, "_bytes_at_done"}, 32'(got.size()), 32'(PLEN));
      end
    end
    chk({tag, "_done_seen"}, {31'h0, seen}, 32'h1);
    for (int i = 0; i < PLEN; i++) begin
      g = (i < got.size()) ? {24'h0, got[i]} : 32'hFFFF_FFFF;
      chk($sformatf("%s_byte%0d", tag, i), g, {24'h0, e[i]});
    end
    chk({tag, "_data_zero_idle"}, 32'(zbad), 32'h0);
    // WAIT_ACK: done is gone, request dropped, still busy
    @(negedge clk);
    report_trig = trig_wait; in_ep_acked = 1'b0;
    in_ep_grant = 1'b0; in_ep_data_free = 1'b0;
    #1 chk({tag, "_done_1cyc"}, {29'h0, in_ep_data_done, in_ep_req, busy}, 32'h1);
    @(negedge clk);
    report_trig = 1'b0; in_ep_acked = 1'b1;
    #1 chk({tag, "_wait_ack_busy"}, {31'h0, busy}, 32'h1);
    @(negedge clk);
    in_ep_acked = 1'b0;
    #1 chk({tag, "_ack_idle"}, {31'h0, busy}, 32'h0);
    m_seq = m_seq + 8'd1;
  endtask

  initial begin
    int n;
    reset = 1'b1; in_ep_grant = 1'b0; in_ep_data_free = 1'b0; in_ep_acked = 1'b0;
    status = 8'h00; report_trig = 1'b0; m_seq = 8'h00;
    #12 chk_outs_zero("rst_outputs");
    @(negedge clk); reset = 1'b0;

    // Quiet block: status 0, no trigger.
    idle_chk(10, "idle_no_trig");

    // Abort mid-packet with reset after byte 1 has been put.
    @(negedge clk);
    status = 8'h5C; report_trig = 1'b1; in_ep_grant = 1'b1; in_ep_data_free = 1'b1;
    n = 0;
    for (int c = 0; c < 50 && n < 2; c++) begin
      @(negedge clk); report_trig = 1'b0;
      #1 if (in_ep_data_put) n++;
    end
    chk("abort_puts", 32'(n), 32'h2);
    @(negedge clk); reset = 1'b1;
    #1 chk_outs_zero("abort_outputs");
    @(negedge clk); reset = 1'b0;
    m_seq = 8'h00;

    // Fresh report of 5C: A2,00,5C(,FE), clean grant/free.
    run_pkt(1'b0, 1'b0, 1'b0, 8'h5C, "pkt5c");
    chk("seq_after_ack", {24'h0, m_seq}, 32'h1);

    // Status changes produce one report each, then nothing.
    @(negedge clk); status = 8'h01;
    run_pkt(1'b1, 1'b0, 1'b0, 8'h01, "chg01");
    @(negedge clk); status = 8'h02;
    run_pkt(1'b1, 1'b0, 1'b0, 8'h02, "chg02");
    idle_chk(20, "no_repeat_after_chg");

    // Triggered reports until seq wraps, last one with a trigger in WAIT_ACK.
    for (int k = 0; k < 254; k++) run_pkt(1'b1, 1'b1, 1'b0, 8'h02, "wrap");
    run_pkt(1'b1, 1'b1, 1'b1, 8'h02, "trig_in_wait");
    run_pkt(1'b1, 1'b0, 1'b0, 8'h02, "followup");
    idle_chk(30, "single_followup");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_report_in_ep.md
USB_REPORT_IN_EP -- requirements
Module: usb_report_in_ep

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: in_ep_req  output  1  request for IN endpoint buffer.
REQ-004 SHALL have port: in_ep_grant  input  1  buffer granted to this block.
REQ-005 SHALL have port: in_ep_data_free  input  1  buffer can accept a byte this cycle.
REQ-006 SHALL have port: in_ep_data_put  output  1  write in_ep_data into buffer this cycle.
REQ-007 SHALL have port: in_ep_data  output  8  byte being written.
REQ-008 SHALL have port: in_ep_data_done  output  1  one-cycle pulse, packet complete.
REQ-009 SHALL have port: in_ep_stall  output  1  constant 0.
REQ-010 SHALL have port: in_ep_acked  input  1  host ACKed the packet.
REQ-011 SHALL have port: status  input  8  application status byte to report.
REQ-012 SHALL have port: report_trig  input  1  one-cycle request to send a report.
REQ-013 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, REQ, PUT, DONE, WAIT_ACK.
REQ-015 Pending flag SHALL set on report_trig, or when status differs from last-sent status register; it SHALL clear on IDLE->REQ.
REQ-016 IDLE->REQ when pending; on this transition SHALL snapshot status into snap register.
REQ-017 in_ep_req SHALL be high in REQ, PUT, DONE; low in IDLE and WAIT_ACK.
REQ-018 REQ->PUT when in_ep_grant high; byte index SHALL be 0 on entry to PUT.
REQ-019 In PUT, in_ep_data_put SHALL be combinational: PUT && in_ep_grant && in_ep_data_free; index SHALL advance only on a put cycle.
REQ-020 Packet bytes: 0 = 8'hA2 header, 1 = seq (8-bit), 2 = snap, 3 = checksum when enabled (REQ-030).
REQ-021 in_ep_data SHALL be the byte at the current index (combinational mux); value 0 outside PUT.
REQ-022 Loss of grant or data_free mid-PUT SHALL hold index and put low; no byte skipped or repeated.
REQ-023 Put of last byte SHALL move PUT->DONE; DONE SHALL assert in_ep_data_done for exactly one cycle, then ->WAIT_ACK.
REQ-024 WAIT_ACK->IDLE on in_ep_acked; same edge SHALL increment seq (8-bit wrap 255->0) and load last-sent status with snap.
REQ-025 report_trig or status change while busy SHALL set pending; serviced after return to IDLE (one further report, not queued multiples).
REQ-026 in_ep_acked outside WAIT_ACK SHALL be ignored.

Reset
REQ-027 Reset SHALL force state IDLE, index 0, seq 0, snap 0, last-sent status 0, pending 0, in_ep_data_done 0, asynchronously.
REQ-028 Outputs during reset: in_ep_req 0, in_ep_data_put 0, in_ep_data 0, in_ep_data_done 0, busy 0, in_ep_stall 0.
REQ-029 Reset mid-packet SHALL abandon the packet; seq SHALL not advance for it.

Configuration
REQ-030 Macro USB_REPORT_CKSUM_EN defined: packet is 4 bytes, byte 3 = XOR of bytes 0..2; undefined: packet is 3 bytes, no checksum logic.

Structure
REQ-031 Shared package usb_report_pkg SHALL hold state enum, header constant 8'hA2, and packet-length constants (3 and 4).
REQ-032 No sub-module is natural; single module.

Verification
REQ-033 Reset, status=8'h00, no trig -> stays IDLE, in_ep_req 0, no puts.
REQ-034 report_trig with status=8'h5C, grant/free always 1, ack 2 cycles after done -> bytes A2,00,5C(,A2^00^5C=FE) then done pulse; seq=1 after ack.
REQ-035 status 8'h01->8'h02 in IDLE -> one report with snap 02, seq as current; no second report until next change.
REQ-036 data_free toggled 1,0,0,1 during PUT -> bytes in order, no duplicate/skip, done only after last byte.
REQ-037 256 acked reports -> seq wraps to 00 on 257th packet; trig during WAIT_ACK -> exactly one follow-up report.
REQ-038 Reset asserted during PUT after byte 1 -> immediate IDLE, outputs 0, next report starts with header and seq unchanged.
